// File: rtl/vm2002_pkg.sv
// -----------------------------------------------------------------------------
// vm2002_pkg
// Shared types for the vending-machine controller family:
//   coins_t      coin encoding used on coin acceptor and change outputs
//   vm_status_t  transaction status reported to the front end
//   vm_state_t   controller FSM states
//   coin_value() coin -> value in nickel units
// -----------------------------------------------------------------------------
package vm2002_pkg;

    typedef enum logic [1:0] {
        NO_COINS = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coins_t;

    typedef enum logic [2:0] {
        NO_STATUS    = 3'd0,
        AVAILABLE    = 3'd1,
        OUT_OF_STOCK = 3'd2,
        INSUFFICIENT = 3'd3,
        ERROR        = 3'd4
    } vm_status_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } vm_state_t;

    function automatic logic [2:0] coin_value(input coins_t c);
        case (c)
            NICKEL:  coin_value = 3'd1;
            DIME:    coin_value = 3'd2;
            QUARTER: coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_controller_if.sv
// -----------------------------------------------------------------------------
// vm_controller_if
// Front-end / actuator bundle of the vending-machine controller.
//   master : coin acceptor, keypad and operator side (drives requests)
//   slave  : the controller (drives reject/dispense/change/status/balance/busy)
// -----------------------------------------------------------------------------
interface vm_controller_if
    import vm2002_pkg::*;
#(
    parameter int IW       = 3,
    parameter int COUNT_W  = 4,
    parameter int AMOUNT_W = 8
);
    logic                coin_valid;
    coins_t              coin;
    logic                select_valid;
    logic [IW-1:0]       select_item;
    logic                cancel;
    logic                restock_en;
    logic [IW-1:0]       restock_item;
    logic [COUNT_W-1:0]  restock_qty;
    logic                cost_we;
    logic [IW-1:0]       cost_item;
    logic [AMOUNT_W-1:0] cost_val;

    logic                coin_reject;
    logic                dispense_valid;
    logic [IW-1:0]       dispense_item;
    logic                change_valid;
    coins_t              change_coin;
    vm_status_t          status;
    logic [AMOUNT_W-1:0] balance;
    logic                busy;

    modport master (
        output coin_valid, coin, select_valid, select_item, cancel,
               restock_en, restock_item, restock_qty,
               cost_we, cost_item, cost_val,
        input  coin_reject, dispense_valid, dispense_item, change_valid,
               change_coin, status, balance, busy
    );

    modport slave (
        input  coin_valid, coin, select_valid, select_item, cancel,
               restock_en, restock_item, restock_qty,
               cost_we, cost_item, cost_val,
        output coin_reject, dispense_valid, dispense_item, change_valid,
               change_coin, status, balance, busy
    );
endinterface

// File: rtl/vm_change_gen.sv
// -----------------------------------------------------------------------------
// vm_change_gen
// Greedy change-coin selector (combinational).
//   balance_i     remaining credit in nickels
//   change_coin_o largest coin not exceeding balance (NO_COINS when zero)
//   dec_o         value of change_coin_o in nickels
// -----------------------------------------------------------------------------
module vm_change_gen
    import vm2002_pkg::*;
#(
    parameter int AMOUNT_W = 8
) (
    input  logic [AMOUNT_W-1:0] balance_i,
    output coins_t              change_coin_o,
    output logic [AMOUNT_W-1:0] dec_o
);
    always_comb begin
        change_coin_o = NO_COINS;
        dec_o         = '0;
        if (balance_i >= AMOUNT_W'(5)) begin
            change_coin_o = QUARTER;
            dec_o         = AMOUNT_W'(5);
        end else if (balance_i >= AMOUNT_W'(2)) begin
            change_coin_o = DIME;
            dec_o         = AMOUNT_W'(2);
        end else if (balance_i != '0) begin
            change_coin_o = NICKEL;
            dec_o         = AMOUNT_W'(1);
        end
    end
endmodule

// File: rtl/vm_controller.sv
// -----------------------------------------------------------------------------
// vm_controller
// Vending-machine controller: coin collection, stock/price check, dispense,
// greedy coin-by-coin change, operator restock and price writes (IDLE only).
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (balance discarded, no refund)
//   bus    vm_controller_if.slave: coin/select/cancel/restock/cost inputs,
//          registered coin_reject/dispense/change/status/balance/busy outputs
// -----------------------------------------------------------------------------
module vm_controller
    import vm2002_pkg::*;
#(
    parameter int N_ITEMS      = 8,
    parameter int COUNT_W      = 4,
    parameter int INIT_COUNT   = 8,
    parameter int AMOUNT_W     = 8,
    parameter int DEFAULT_COST = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    vm_controller_if.slave   bus
);
    localparam int IW  = $clog2(N_ITEMS);
    localparam int AW1 = AMOUNT_W + 1;
    localparam int CW1 = COUNT_W + 1;

    vm_state_t           state_q, state_d;
    logic [AMOUNT_W-1:0] balance_q, balance_d;
    logic [IW-1:0]       item_q, item_d;
    vm_status_t          status_q, status_d;
    logic                coin_reject_q, coin_reject_d;
    logic                dispense_valid_q, dispense_valid_d;
    logic [IW-1:0]       dispense_item_q, dispense_item_d;
    logic                change_valid_q, change_valid_d;
    coins_t              change_coin_q, change_coin_d;
    logic [COUNT_W-1:0]  count_q [N_ITEMS];
    logic [COUNT_W-1:0]  count_d [N_ITEMS];
    logic [AMOUNT_W-1:0] cost_q  [N_ITEMS];
    logic [AMOUNT_W-1:0] cost_d  [N_ITEMS];

    logic                coin_ok;
    logic [AW1-1:0]      coin_sum;
    logic [CW1-1:0]      restock_sum;
    logic [AMOUNT_W-1:0] bal_after;
    logic                item_err;
    coins_t              gen_coin;
    logic [AMOUNT_W-1:0] gen_dec;

    vm_change_gen #(.AMOUNT_W(AMOUNT_W)) u_change_gen (
        .balance_i     (balance_q),
        .change_coin_o (gen_coin),
        .dec_o         (gen_dec)
    );

    always_comb begin
        state_d          = state_q;
        balance_d        = balance_q;
        item_d           = item_q;
        status_d         = status_q;
        coin_reject_d    = 1'b0;
        dispense_valid_d = 1'b0;
        dispense_item_d  = dispense_item_q;
        change_valid_d   = 1'b0;
        change_coin_d    = NO_COINS;
        count_d          = count_q;
        cost_d           = cost_q;

        coin_ok     = bus.coin_valid && (bus.coin != NO_COINS);
        // Carry bit flags a credit that would not fit in AMOUNT_W.
        coin_sum    = {1'b0, balance_q} + AW1'(coin_value(bus.coin));
        restock_sum = {1'b0, count_q[bus.restock_item]} + {1'b0, bus.restock_qty};
        bal_after   = balance_q - cost_q[item_q];
        item_err    = 32'(item_q) >= 32'(N_ITEMS);

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (coin_ok) begin
                    if (coin_sum[AMOUNT_W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        balance_d = coin_sum[AMOUNT_W-1:0];
                        state_d   = ST_COLLECT;
                    end
                end
                if (state_q == ST_IDLE) begin
                    if (bus.restock_en)
                        count_d[bus.restock_item] = restock_sum[COUNT_W] ?
                            '1 : restock_sum[COUNT_W-1:0];
                    if (bus.cost_we)
                        cost_d[bus.cost_item] = bus.cost_val;
                end else if (bus.cancel) begin
                    state_d = ST_CHANGE;
                end else if (bus.select_valid) begin
                    item_d  = bus.select_item;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                coin_reject_d = coin_ok;
                state_d       = ST_COLLECT;
                if (item_err) begin
                    status_d = ERROR;
                end else if (count_q[item_q] == '0) begin
                    status_d = OUT_OF_STOCK;
                end else if (balance_q < cost_q[item_q]) begin
                    status_d = INSUFFICIENT;
                end else begin
                    // Pulse registered here so it is visible during DISPENSE.
                    status_d         = AVAILABLE;
                    state_d          = ST_DISPENSE;
                    dispense_valid_d = 1'b1;
                    dispense_item_d  = item_q;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d    = coin_ok;
                count_d[item_q]  = count_q[item_q] - COUNT_W'(1);
                balance_d        = bal_after;
                state_d          = (bal_after == '0) ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_ok;
                if (balance_q == '0) begin
                    state_d  = ST_IDLE;
                    status_d = NO_STATUS;
                end else begin
                    change_valid_d = 1'b1;
                    change_coin_d  = gen_coin;
                    balance_d      = balance_q - gen_dec;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            balance_q        <= '0;
            item_q           <= '0;
            status_q         <= NO_STATUS;
            coin_reject_q    <= 1'b0;
            dispense_valid_q <= 1'b0;
            dispense_item_q  <= '0;
            change_valid_q   <= 1'b0;
            change_coin_q    <= NO_COINS;
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                count_q[i] <= COUNT_W'(INIT_COUNT);
                cost_q[i]  <= AMOUNT_W'(DEFAULT_COST);
            end
        end else begin
            state_q          <= state_d;
            balance_q        <= balance_d;
            item_q           <= item_d;
            status_q         <= status_d;
            coin_reject_q    <= coin_reject_d;
            dispense_valid_q <= dispense_valid_d;
            dispense_item_q  <= dispense_item_d;
            change_valid_q   <= change_valid_d;
            change_coin_q    <= change_coin_d;
            count_q          <= count_d;
            cost_q           <= cost_d;
        end
    end

    assign bus.coin_reject    = coin_reject_q;
    assign bus.dispense_valid = dispense_valid_q;
    assign bus.dispense_item  = dispense_item_q;
    assign bus.change_valid   = change_valid_q;
    assign bus.change_coin    = change_coin_q;
    assign bus.status         = status_q;
    assign bus.balance        = balance_q;
    assign bus.busy           = (state_q != ST_IDLE) && (state_q != ST_COLLECT);
endmodule

// File: tb/tb_vm_controller.sv
// -----------------------------------------------------------------------------
// tb_vm_controller
// Directed bench for vm_controller: purchases with and without change,
// stock/price checks, cancel refund, balance overflow, restock saturation and
// asynchronous reset mid-transaction.
// -----------------------------------------------------------------------------
module tb_vm_controller;
    import vm2002_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    vm_controller_if #(.IW(3), .COUNT_W(4), .AMOUNT_W(8)) bus ();

    vm_controller #(
        .N_ITEMS(8), .COUNT_W(4), .INIT_COUNT(8), .AMOUNT_W(8), .DEFAULT_COST(20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic insert_coin(input coins_t c);
        bus.coin_valid = 1'b1;
        bus.coin       = c;
        step();
        bus.coin_valid = 1'b0;
        bus.coin       = NO_COINS;
    endtask

    task automatic do_select(input logic [2:0] item);
        bus.select_item  = item;
        bus.select_valid = 1'b1;
        step();
        bus.select_valid = 1'b0;
    endtask

    task automatic collect_change(output int sum, output int n, output int nq, output int nd);
        sum = 0; n = 0; nq = 0; nd = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.change_valid) begin
                n++;
                case (bus.change_coin)
                    QUARTER: begin sum += 5; nq++; end
                    DIME:    begin sum += 2; nd++; end
                    NICKEL:  sum += 1;
                    default: ;
                endcase
            end
            if (!bus.busy) break;
        end
        check("change_done", {31'd0, bus.busy}, 32'd0);
    endtask

    int sum, n, nq, nd;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.coin_valid   = 1'b0;
        bus.coin         = NO_COINS;
        bus.select_valid = 1'b0;
        bus.select_item  = '0;
        bus.cancel       = 1'b0;
        bus.restock_en   = 1'b0;
        bus.restock_item = '0;
        bus.restock_qty  = '0;
        bus.cost_we      = 1'b0;
        bus.cost_item    = '0;
        bus.cost_val     = '0;
        step();
        step();

        // Reset state
        check("rst_balance", 32'(bus.balance), 0);
        check("rst_status", 32'(bus.status), 32'(NO_STATUS));
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_dispense", {31'd0, bus.dispense_valid}, 0);
        check("rst_change", {31'd0, bus.change_valid}, 0);
        check("rst_count1", 32'(dut.count_q[1]), 8);
        rst_n = 1'b1;
        step();

        // 4 quarters, slot 1 at cost 20: exact payment
        repeat (4) insert_coin(QUARTER);
        check("t1_balance", 32'(bus.balance), 20);
        do_select(3'd1);
        check("t1_check_busy", {31'd0, bus.busy}, 1);
        check("t1_no_disp_yet", {31'd0, bus.dispense_valid}, 0);
        step();
        check("t1_disp_valid", {31'd0, bus.dispense_valid}, 1);
        check("t1_disp_item", 32'(bus.dispense_item), 1);
        check("t1_status", 32'(bus.status), 32'(AVAILABLE));
        step();
        check("t1_disp_pulse", {31'd0, bus.dispense_valid}, 0);
        check("t1_bal0", 32'(bus.balance), 0);
        check("t1_idle", {31'd0, bus.busy}, 0);
        check("t1_count1", 32'(dut.count_q[1]), 7);
        check("t1_no_change", {31'd0, bus.change_valid}, 0);

        // 5 quarters, slot 0: one quarter of change
        repeat (5) insert_coin(QUARTER);
        do_select(3'd0);
        step();
        check("t2_disp_item", 32'(bus.dispense_item), 0);
        step();
        check("t2_bal_after", 32'(bus.balance), 5);
        collect_change(sum, n, nq, nd);
        check("t2_change_sum", 32'(sum), 5);
        check("t2_change_n", 32'(n), 1);
        check("t2_quarters", 32'(nq), 1);
        check("t2_bal0", 32'(bus.balance), 0);

        // Slot 2 repriced to 3; quarter leaves 2 -> one dime; coin during CHANGE rejected
        bus.cost_we = 1'b1; bus.cost_item = 3'd2; bus.cost_val = 8'd3;
        step();
        bus.cost_we = 1'b0;
        check("t3_cost2", 32'(dut.cost_q[2]), 3);
        insert_coin(QUARTER);
        do_select(3'd2);
        step();
        check("t3_disp", {31'd0, bus.dispense_valid}, 1);
        step();
        check("t3_bal_after", 32'(bus.balance), 2);
        bus.coin_valid = 1'b1; bus.coin = QUARTER;
        step();
        bus.coin_valid = 1'b0; bus.coin = NO_COINS;
        check("t3_reject", {31'd0, bus.coin_reject}, 1);
        check("t3_chg_valid", {31'd0, bus.change_valid}, 1);
        check("t3_chg_coin", 32'(bus.change_coin), 32'(DIME));
        check("t3_bal0", 32'(bus.balance), 0);
        step();
        check("t3_idle", {31'd0, bus.busy}, 0);
        check("t3_status_clr", 32'(bus.status), 32'(NO_STATUS));
        check("t3_reject_pulse", {31'd0, bus.coin_reject}, 0);

        // Drain slot 3 (repriced to 1 nickel), then out-of-stock + cancel refund
        bus.cost_we = 1'b1; bus.cost_item = 3'd3; bus.cost_val = 8'd1;
        step();
        bus.cost_we = 1'b0;
        repeat (8) begin
            insert_coin(NICKEL);
            do_select(3'd3);
            step();
            step();
        end
        check("t4_count3", 32'(dut.count_q[3]), 0);
        insert_coin(DIME);
        insert_coin(QUARTER);
        do_select(3'd3);
        step();
        check("t4_oos", 32'(bus.status), 32'(OUT_OF_STOCK));
        check("t4_bal_kept", 32'(bus.balance), 7);
        check("t4_no_disp", {31'd0, bus.dispense_valid}, 0);
        // Restock is ignored outside IDLE
        bus.restock_en = 1'b1; bus.restock_item = 3'd0; bus.restock_qty = 4'd1;
        step();
        bus.restock_en = 1'b0;
        check("t4_restock_ignored", 32'(dut.count_q[0]), 7);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        collect_change(sum, n, nq, nd);
        check("t4_refund_sum", 32'(sum), 7);
        check("t4_refund_n", 32'(n), 2);
        check("t4_refund_dimes", 32'(nd), 1);
        check("t4_bal0", 32'(bus.balance), 0);

        // Insufficient funds, then coin+select in the same cycle
        bus.cost_we = 1'b1; bus.cost_item = 3'd6; bus.cost_val = 8'd7;
        step();
        bus.cost_we = 1'b0;
        insert_coin(DIME);
        do_select(3'd6);
        step();
        check("t5_insuff", 32'(bus.status), 32'(INSUFFICIENT));
        check("t5_bal_kept", 32'(bus.balance), 2);
        bus.coin_valid = 1'b1; bus.coin = QUARTER;
        do_select(3'd6);
        bus.coin_valid = 1'b0; bus.coin = NO_COINS;
        check("t5_credit", 32'(bus.balance), 7);
        step();
        check("t5_disp", {31'd0, bus.dispense_valid}, 1);
        check("t5_disp_item", 32'(bus.dispense_item), 6);
        step();
        check("t5_idle", {31'd0, bus.busy}, 0);
        check("t5_bal0", 32'(bus.balance), 0);

        // Balance overflow boundary at 255
        repeat (50) insert_coin(QUARTER);
        check("t6_bal250", 32'(bus.balance), 250);
        insert_coin(DIME);
        insert_coin(DIME);
        check("t6_bal254", 32'(bus.balance), 254);
        insert_coin(DIME);
        check("t6_reject_dime", {31'd0, bus.coin_reject}, 1);
        check("t6_bal_hold", 32'(bus.balance), 254);
        insert_coin(NICKEL);
        check("t6_accept_nickel", {31'd0, bus.coin_reject}, 0);
        check("t6_bal255", 32'(bus.balance), 255);
        insert_coin(NICKEL);
        check("t6_reject_nickel", {31'd0, bus.coin_reject}, 1);
        check("t6_bal255_hold", 32'(bus.balance), 255);

        // Reset during CHANGE
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        step();
        step();
        check("t7_in_change", {31'd0, bus.change_valid}, 1);
        check("t7_bal_mid", 32'(bus.balance), 245);
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", {31'd0, bus.busy}, 0);
        check("t7_rst_bal", 32'(bus.balance), 0);
        check("t7_rst_change", {31'd0, bus.change_valid}, 0);
        check("t7_rst_status", 32'(bus.status), 32'(NO_STATUS));
        check("t7_rst_cost2", 32'(dut.cost_q[2]), 20);
        step();
        rst_n = 1'b1;
        step();

        // Restock saturation on slot 4
        bus.restock_en = 1'b1; bus.restock_item = 3'd4; bus.restock_qty = 4'd4;
        step();
        check("t8_restock12", 32'(dut.count_q[4]), 12);
        bus.restock_qty = 4'd10;
        step();
        bus.restock_en = 1'b0;
        check("t8_restock_sat", 32'(dut.count_q[4]), 15);
        check("t8_other_slot", 32'(dut.count_q[5]), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
